// File: rtl/mem_transfer_datapath_if.sv
// Strobe/data bundle between the memory-transfer controller and its datapath.
// The controller side uses the master modport; the datapath uses slave.
interface mem_transfer_datapath_if #(
  parameter int DATA_W = 8
);
  logic              incA;
  logic              incB;
  logic              weA;
  logic              weB;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        rd_sel;
  logic [DATA_W-1:0] b_data;
  logic [2:0]        addrA;
  logic [1:0]        addrB;
  logic              done;
  logic              ovf;

  modport master (
    output incA, incB, weA, weB, data_in, rd_sel,
    input  b_data, addrA, addrB, done, ovf
  );

  modport slave (
    input  incA, incB, weA, weB, data_in, rd_sel,
    output b_data, addrA, addrB, done, ovf
  );
endinterface

// File: rtl/mem_transfer_datapath.sv
// Two address counters, 8-word source memory A, 4-word destination memory B and
// the pairwise combine unit (difference if first word larger, otherwise sum).
module mem_transfer_datapath #(
  parameter int DATA_W = 8
) (
  input logic                    clock,
  input logic                    reset,
  mem_transfer_datapath_if.slave bus
);

  localparam logic [2:0] WCNT_MAX = 3'd4;

  logic [2:0]        r_addrA;
  logic [1:0]        r_addrB;
  logic [DATA_W-1:0] r_held;
  logic [DATA_W-1:0] r_memA [8];
  logic [DATA_W-1:0] r_memB [4];
  logic [2:0]        r_wcnt;
  logic              r_ovf;

  logic [DATA_W-1:0] w_curA;
  logic [DATA_W:0]   w_comb;
  logic [DATA_W-1:0] w_res;
  logic              w_carry;

  // Top bit is the carry out; it can only be set by the sum branch.
  function automatic logic [DATA_W:0] combine(input logic [DATA_W-1:0] h,
                                              input logic [DATA_W-1:0] c);
    if (h > c) return {1'b0, h - c};
    else       return {1'b0, h} + {1'b0, c};
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
    if (cnt >= WCNT_MAX) return WCNT_MAX;
    else                 return cnt + 3'd1;
  endfunction

  assign w_curA  = r_memA[r_addrA];
  assign w_comb  = combine(r_held, w_curA);
  assign w_res   = w_comb[DATA_W-1:0];
  assign w_carry = w_comb[DATA_W];

  // Counters, hold register and status
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addrA <= '0;
      r_addrB <= '0;
      r_held  <= '0;
      r_wcnt  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.incA) begin
        r_addrA <= r_addrA + 3'd1;
        r_held  <= w_curA;
      end
      if (bus.incB) r_addrB <= r_addrB + 2'd1;
      if (bus.weB) begin
        r_wcnt <= sat_inc(r_wcnt);
        if (w_carry) r_ovf <= 1'b1;
      end
    end
  end

  // Memory arrays; writes use the pre-increment addresses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_memA[i] <= '0;
      for (int i = 0; i < 4; i++) r_memB[i] <= '0;
    end else begin
      if (bus.weA) r_memA[r_addrA] <= bus.data_in;
      if (bus.weB) r_memB[r_addrB] <= w_res;
    end
  end

  assign bus.b_data = r_memB[bus.rd_sel];
  assign bus.addrA  = r_addrA;
  assign bus.addrB  = r_addrB;
  assign bus.done   = (r_wcnt == WCNT_MAX);
  assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_mem_transfer_datapath.sv
// Bench for mem_transfer_datapath: table-driven load/transfer vectors plus
// hand-written reset, overflow, simultaneous-strobe and wrap sequences.
module tb_mem_transfer_datapath;

  logic clock = 1'b0;
  logic reset = 1'b0;

  mem_transfer_datapath_if #(.DATA_W(8)) bus ();

  mem_transfer_datapath #(.DATA_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] val;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic       weB;
    logic       incB;
    logic [7:0] exp_res;
    logic [2:0] exp_addrA;
    logic [1:0] exp_addrB;
    logic       exp_done;
  } xfer_vec_t;

  logic [7:0] load_data [8];
  xfer_vec_t  xfer_tbl  [8];
  logic [1:0] cur_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.incA = 1'b0; bus.incB = 1'b0; bus.weA = 1'b0; bus.weB = 1'b0;
  endtask

  task automatic drive(input logic wa, input logic ia, input logic wb, input logic ib,
                       input logic [7:0] d);
    bus.weA = wa; bus.incA = ia; bus.weB = wb; bus.incB = ib; bus.data_in = d;
    step();
    idle();
  endtask

  task automatic push_b(input logic [1:0] a, input logic [7:0] v);
    sb_t e;
    e.addr = a;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  // Strobes are idle here, so any clock edge during the reads is harmless.
  task automatic drain(input string name);
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.rd_sel = e.addr;
      #1;
      check($sformatf("%s_B%0d", name, e.addr), bus.b_data, e.val);
    end
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
  endtask

  task automatic spin_a(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    load_data = '{8'd10, 8'd3, 8'd7, 8'd9, 8'd200, 8'd100, 8'd5, 8'd5};
    xfer_tbl[0] = '{1'b1, 1'b0, 8'd7,   3'd2, 2'd0, 1'b0};
    xfer_tbl[1] = '{1'b0, 1'b1, 8'd0,   3'd3, 2'd1, 1'b0};
    xfer_tbl[2] = '{1'b1, 1'b0, 8'd16,  3'd4, 2'd1, 1'b0};
    xfer_tbl[3] = '{1'b0, 1'b1, 8'd0,   3'd5, 2'd2, 1'b0};
    xfer_tbl[4] = '{1'b1, 1'b0, 8'd100, 3'd6, 2'd2, 1'b0};
    xfer_tbl[5] = '{1'b0, 1'b1, 8'd0,   3'd7, 2'd3, 1'b0};
    xfer_tbl[6] = '{1'b1, 1'b0, 8'd10,  3'd0, 2'd3, 1'b1};
    xfer_tbl[7] = '{1'b0, 1'b1, 8'd0,   3'd1, 2'd0, 1'b1};

    idle();
    bus.data_in = 8'd0;
    bus.rd_sel  = 2'd0;
    #12;
    reset = 1'b1;
    step();

    check("rst_addrA", bus.addrA, 0);
    check("rst_addrB", bus.addrB, 0);
    check("rst_done",  bus.done,  0);
    check("rst_ovf",   bus.ovf,   0);

    // Load phase
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, load_data[i]);
      check($sformatf("load_addrA_%0d", i), bus.addrA, (i + 1) % 8);
    end
    spin_a(8);
    check("reload_addrA", bus.addrA, 0);
    spin_a(1);

    // Transfer cadence: held = A[0], curA = A[1]
    cur_b = 2'd0;
    for (int i = 0; i < 8; i++) begin
      if (xfer_tbl[i].weB) push_b(cur_b, xfer_tbl[i].exp_res);
      drive(1'b0, 1'b1, xfer_tbl[i].weB, xfer_tbl[i].incB, 8'd0);
      check($sformatf("xfer_addrA_%0d", i), bus.addrA, xfer_tbl[i].exp_addrA);
      check($sformatf("xfer_addrB_%0d", i), bus.addrB, xfer_tbl[i].exp_addrB);
      check($sformatf("xfer_done_%0d", i),  bus.done,  xfer_tbl[i].exp_done);
      check($sformatf("xfer_ovf_%0d", i),   bus.ovf,   0);
      cur_b = xfer_tbl[i].exp_addrB;
    end
    drain("xfer");

    // Asynchronous reset mid-run, observed before any clock edge
    spin_a(3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    reset = 1'b0;
    #2;
    check("arst_addrA", bus.addrA, 0);
    check("arst_addrB", bus.addrB, 0);
    check("arst_done",  bus.done,  0);
    check("arst_ovf",   bus.ovf,   0);
    for (int r = 0; r < 4; r++) begin
      bus.rd_sel = 2'(r);
      #1;
      check($sformatf("arst_B%0d", r), bus.b_data, 0);
    end
    reset = 1'b1;
    step();

    // Overflow: 100 + 200 = 300 -> 44 with carry, then 200 - 0 keeps ovf set
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd100);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd200);
    spin_a(7);
    check("ovf_pre", bus.ovf, 0);
    push_b(2'd0, 8'd44);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
    check("ovf_set", bus.ovf, 1);
    push_b(2'd1, 8'd200);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    check("ovf_sticky", bus.ovf, 1);
    drain("ovf");

    // Simultaneous strobes at addrA=2, addrB=1 with held=22, memA[2]=5
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd11);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd22);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    spin_a(7);
    check("sim_pre_addrA", bus.addrA, 2);
    check("sim_pre_addrB", bus.addrB, 1);
    push_b(2'd1, 8'd17);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'd99);
    check("sim_addrA", bus.addrA, 3);
    check("sim_addrB", bus.addrB, 2);
    spin_a(7);
    push_b(2'd2, 8'd121);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    drain("sim");

    // Equal values and addrB wrap
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
    spin_a(7);
    for (int i = 0; i < 5; i++) begin
      push_b(2'(i % 4), 8'd10);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
      check($sformatf("wrap_addrB_%0d", i), bus.addrB, (i + 1) % 4);
      check($sformatf("wrap_done_%0d", i),  bus.done,  (i >= 3) ? 1 : 0);
    end
    check("wrap_ovf", bus.ovf, 0);
    drain("wrap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_transfer_datapath.md
# mem_transfer_datapath

Datapath stage driven directly by the memory-transfer controller. It consumes the controller's `incA`, `incB`, `weA` and `weB` strobes, which drive two address counters, an 8x8 source memory A and a 4x8 destination memory B. During the load phase, input words are written into memory A. During the transfer phase, each pair of consecutive A words is combined (difference if the first is larger, otherwise sum) and written into memory B, with completion and overflow status reported to the system.

## Interface
- `DATA_W`, 8, word width of both memories and of `data_in` / `b_data`
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset; `reset`=0 clears all state immediately
- `incA`  in  1  advance memory-A address counter and reload hold register
- `incB`  in  1  advance memory-B address counter
- `weA`  in  1  write `data_in` into memory A at the current A address
- `weB`  in  1  write combine result into memory B at the current B address
- `data_in`  in  DATA_W  load-phase input word
- `rd_sel`  in  2  independent read select for memory B
- `b_data`  out  DATA_W  memB[`rd_sel`], combinational
- `addrA`  out  3  current memory-A address
- `addrB`  out  2  current memory-B address
- `done`  out  1  sticky; set once 4 memory-B writes have occurred since reset
- `ovf`  out  1  sticky; set when any sum written to B exceeded 2^DATA_W-1

## Operation
- **Address counters**
  - `addrA` is 3-bit. It increments on each edge with `incA`=1 and wraps 7->0.
  - `addrB` is 2-bit. It increments on each edge with `incB`=1 and wraps 3->0.
- **Memory reads**
  - `curA` = memA[`addrA`], combinational. It reflects the stored contents, so a same-cycle write is not visible.
  - `held` is a DATA_W register. It loads `curA` on every edge with `incA`=1 and holds otherwise.
- **Combine function**, unsigned, evaluated combinationally:
  - if `held` > `curA`: `res` = `held` - `curA` (never negative)
  - else: `res` = (`held` + `curA`) mod 2^DATA_W; carry out = `held` + `curA` >= 2^DATA_W
- **Write A**: `weA`=1 writes memA[`addrA`] <= `data_in`.
- **Write B**: `weB`=1 writes memB[`addrB`] <= `res`, and the 3-bit write counter `wcnt` increments, saturating at 4.
  - `done` = (`wcnt` == 4).
  - `ovf` sets on any `weB` edge where the sum branch was taken and carry out = 1. It clears only on reset.
- **Simultaneous events**
  - `weA`+`incA`: the write uses the pre-increment address. `held` captures the old memA[`addrA`] contents.
  - `weB`+`incB`: the write uses the pre-increment `addrB`.
  - `weA` and `weB` are independent and may coincide.
  - All four strobes at once are legal, with each rule above applied from the same pre-edge state.
- Strobes are don't-care while `reset`=0.

## Timing
- Asynchronous assert of `reset`=0 clears, without waiting for a clock edge:
  - `addrA`=0, `addrB`=0, `held`=0, `wcnt`=0, `done`=0, `ovf`=0
  - all memA and memB words = 0, so `b_data`=0 for every `rd_sel`
- Release is sampled at a rising edge. The first state update is on the first edge with `reset`=1.
- **Latency**
  - Counters, memories, `held`, `done` and `ovf` all update 1 edge after the strobe is sampled.
  - `b_data` follows `rd_sel` and memory B contents combinationally, with 0 cycles latency.
- **Expected transfer cadence.** With `incA`=1 every cycle, a `weB` on cycle t combines A[k] (in `held`) with A[k+1] (`curA`).
  - `incB` on t+1 advances B.
  - `weB` on t+2 combines A[k+2] with A[k+3].
  - Pairs are therefore (0,1), (2,3), (4,5), (6,7).
- A reset mid-transfer aborts immediately. No partial write to memB completes on the edge where `reset`=0.
- `done` stays 1 after further `weB` writes, including writes that wrap `addrB`.

## Test plan
- **Reset**: drive `reset`=0 mid-run, then release.
  - `addrA`=0, `addrB`=0, `done`=0, `ovf`=0.
  - `b_data`=0 for `rd_sel`=0..3.
  - Reset takes effect before the next clock edge.
- **Load**: 8 cycles of `weA`=1, `incA`=1 with `data_in` = 10,3,7,9,200,100,5,5.
  - `addrA` wraps to 0.
  - A second incA-only pass leaves memory A unchanged.
- **Transfer**: after the load, apply the cadence `incA` every cycle, with `weB`/`incB` alternating starting at `held`=A[0].
  - memB = 7,16,100,10.
  - `done`=1 after the 4th `weB`.
  - `ovf`=0 throughout.
- **Overflow**: load A[0]=100, A[1]=200 and transfer one pair.
  - B[0]=44 and `ovf`=1.
  - `ovf` stays 1 through later non-overflowing writes until reset.
- **Simultaneous strobes**: apply `weA`+`incA`+`weB`+`incB` in one cycle at `addrA`=2, `addrB`=1.
  - memA[2] = `data_in`.
  - memB[1] = f(old `held`, old memA[2]).
  - `addrA`=3, `addrB`=2.
- **Equal values and wrap**: load A[0]=A[1]=5 and perform 5 `weB` writes.
  - B[0]=10 (sum branch).
  - `addrB` wraps 3->0.
  - `done` remains 1 and `wcnt` saturates at 4.
